// File: rtl/jk_seq_ctrl_pkg.sv
// Shared definitions for the JK sequencer: FSM encodings and {A,B} state codes.
package jk_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // {A,B} codes along the x=0 walk 00 -> 10 -> 11 -> 01 -> 00
  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S01 = 2'b01;

endpackage

// File: rtl/jk_seq_ctrl_jk_cell.sv
// Single JK flip-flop with synchronous reset, parallel load and step enable.
// Also exposes its combinational next value so the controller can look ahead.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic d,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_nx
);

  assign q_nx = (j & ~q) | (~k & q);

  // Flip-flop: reset, then load, then JK step when enabled
  always_ff @(posedge clk) begin
    if (rst)       q <= 1'b0;
    else if (load) q <= d;
    else if (en)   q <= q_nx;
  end

endmodule

// File: rtl/jk_seq_ctrl.sv
// Sequencer for the two-bit JK state machine: loads a start state, feeds a
// captured x pattern one bit per clock, stops on length or target match.
module jk_seq_ctrl
  import jk_seq_ctrl_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int CW      = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         init_state,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [CW-1:0]      len,
  input  logic               match_en,
  input  logic [1:0]         target,
  input  logic               abort,
  output logic               x_out,
  output logic [1:0]         state,
  output logic [CW-1:0]      steps,
  output logic               busy,
  output logic               done,
  output logic               hit,
  output logic               aborted
);

  localparam logic [CW-1:0] MAX_LEN_C = CW'(MAX_LEN);

  fsm_t               fsm;
  logic [MAX_LEN-1:0] pat_r;
  logic [CW-1:0]      len_r;
  logic               men_r;
  logic [1:0]         tgt_r;

  logic               a_q, b_q, a_nx, b_nx;
  logic               x;
  logic               accept, step_en;
  logic [MAX_LEN-1:0] pat_sh;
  logic [CW-1:0]      steps_inc;
  logic [CW-1:0]      len_c;
  logic               cnt_end, match;

  function automatic logic [CW-1:0] clamp_len(input logic [CW-1:0] l);
    return (l > MAX_LEN_C) ? MAX_LEN_C : l;
  endfunction

  // x is only ever non-zero while running; busy is the registered RUN flag
  assign pat_sh  = pat_r >> steps;
  assign x       = busy & pat_sh[0];
  assign x_out   = x;

  assign accept  = (fsm == IDLE) & start;
  assign step_en = (fsm == RUN) & ~abort;
  assign len_c   = clamp_len(len);

  assign steps_inc = steps + 1'b1;
  assign cnt_end   = (steps_inc == len_r);
  assign match     = men_r & ({a_nx, b_nx} == tgt_r);

  assign state = {a_q, b_q};

  jk_cell u_cell_a (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .d    (init_state[1]),
    .en   (step_en),
    .j    (~b_q & ~x),
    .k    (b_q & ~x),
    .q    (a_q),
    .q_nx (a_nx)
  );

  jk_cell u_cell_b (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .d    (init_state[0]),
    .en   (step_en),
    .j    (a_q & ~x),
    .k    (~a_q & ~x),
    .q    (b_q),
    .q_nx (b_nx)
  );

  // Run control: capture on accepted start, count steps, stop/abort, status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm     <= IDLE;
      pat_r   <= '0;
      len_r   <= '0;
      men_r   <= 1'b0;
      tgt_r   <= 2'b00;
      steps   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hit     <= 1'b0;
      aborted <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          done    <= 1'b0;
          aborted <= 1'b0;
          if (start) begin
            pat_r <= pattern;
            len_r <= len_c;
            men_r <= match_en;
            tgt_r <= target;
            steps <= '0;
            hit   <= 1'b0;
            if (len_c != '0) begin
              fsm  <= RUN;
              busy <= 1'b1;
            end else begin
              fsm  <= DONE;
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          // abort wins over the stop condition and performs no step
          if (abort) begin
            fsm     <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else begin
            steps <= steps_inc;
            if (cnt_end || match) begin
              fsm  <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
              hit  <= match;
            end
          end
        end
        DONE: begin
          done <= 1'b0;
          fsm  <= IDLE;
        end
        default: begin
          fsm  <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Directed bench for jk_seq_ctrl.
module tb_jk_seq_ctrl;
  import jk_seq_ctrl_pkg::*;

  localparam int MAX_LEN = 16;
  localparam int CW      = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [1:0]         init_state;
  logic [MAX_LEN-1:0] pattern;
  logic [CW-1:0]      len;
  logic               match_en;
  logic [1:0]         target;
  logic               abort;
  logic               x_out;
  logic [1:0]         state;
  logic [CW-1:0]      steps;
  logic               busy, done, hit, aborted;

  int checks = 0;
  int errors = 0;

  jk_seq_ctrl #(.MAX_LEN(MAX_LEN), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .init_state(init_state),
    .pattern(pattern), .len(len), .match_en(match_en), .target(target),
    .abort(abort), .x_out(x_out), .state(state), .steps(steps),
    .busy(busy), .done(done), .hit(hit), .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [1:0] ini, input logic [15:0] pat, input logic [CW-1:0] l,
                    input logic men, input logic [1:0] tgt);
    init_state = ini;
    pattern    = pat;
    len        = l;
    match_en   = men;
    target     = tgt;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; init_state = 2'b00; pattern = '0; len = '0;
    match_en = 1'b0; target = 2'b00; abort = 1'b0;
    tick(); tick();
    chk("rst_state", 32'(state), 32'(S00));
    chk("rst_steps", 32'(steps), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_hit",   32'(hit), 0);
    chk("rst_xout",  32'(x_out), 0);
    rst = 1'b0;
    tick();

    // Test 1: x=0 walk over four steps
    go(S00, 16'h0000, 5'd4, 1'b0, S00);
    chk("t1_busy0", 32'(busy), 1);
    chk("t1_st0",   32'(state), 32'(S00));
    tick(); chk("t1_st1", 32'(state), 32'(S10)); chk("t1_steps1", 32'(steps), 1);
    tick(); chk("t1_st2", 32'(state), 32'(S11));
    tick(); chk("t1_st3", 32'(state), 32'(S01)); chk("t1_done3", 32'(done), 0);
    tick();
    chk("t1_st4",    32'(state), 32'(S00));
    chk("t1_steps4", 32'(steps), 4);
    chk("t1_done",   32'(done), 1);
    chk("t1_busy",   32'(busy), 0);
    chk("t1_hit",    32'(hit), 0);
    tick(); chk("t1_done_clr", 32'(done), 0);

    // Test 2: alternating x = 0,1,0,1
    go(S00, 16'h000A, 5'd4, 1'b0, S00);
    chk("t2_x0", 32'(x_out), 0);
    tick(); chk("t2_st1", 32'(state), 32'(S10)); chk("t2_x1", 32'(x_out), 1);
    tick(); chk("t2_st2", 32'(state), 32'(S10)); chk("t2_x2", 32'(x_out), 0);
    tick(); chk("t2_st3", 32'(state), 32'(S11)); chk("t2_x3", 32'(x_out), 1);
    tick();
    chk("t2_st4",  32'(state), 32'(S11));
    chk("t2_done", 32'(done), 1);
    chk("t2_xidle", 32'(x_out), 0);
    tick();

    // Test 3: early stop on target 01 after three steps
    go(S00, 16'h0000, 5'd8, 1'b1, S01);
    tick(); tick(); chk("t3_done2", 32'(done), 0);
    tick();
    chk("t3_state", 32'(state), 32'(S01));
    chk("t3_steps", 32'(steps), 3);
    chk("t3_hit",   32'(hit), 1);
    chk("t3_done",  32'(done), 1);
    tick(); chk("t3_hit_held", 32'(hit), 1);

    // Test 4: zero length goes straight to DONE
    go(S11, 16'h0000, 5'd0, 1'b0, S00);
    chk("t4_done",  32'(done), 1);
    chk("t4_busy",  32'(busy), 0);
    chk("t4_state", 32'(state), 32'(S11));
    chk("t4_steps", 32'(steps), 0);
    chk("t4_hit",   32'(hit), 0);
    tick();

    // Test 5: len 20 clamps to 16, x=1 holds, mid-run start ignored
    go(S10, 16'hFFFF, 5'd20, 1'b0, S00);
    for (int i = 1; i <= 16; i++) begin
      if (i == 3) begin init_state = S00; len = 5'd1; start = 1'b1; end
      tick();
      start = 1'b0;
      if (i == 15) chk("t5_done15", 32'(done), 0);
    end
    chk("t5_done",  32'(done), 1);
    chk("t5_steps", 32'(steps), 16);
    chk("t5_state", 32'(state), 32'(S10));
    start = 1'b1;  // start while in DONE must be dropped
    tick();
    start = 1'b0;
    chk("t5_done_clr", 32'(done), 0);
    tick();
    chk("t5_noqueue", 32'(busy), 0);

    // Test 6: abort at step 2
    go(S00, 16'h0000, 5'd4, 1'b0, S00);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_aborted", 32'(aborted), 1);
    chk("t6_state",   32'(state), 32'(S11));
    chk("t6_steps",   32'(steps), 2);
    chk("t6_busy",    32'(busy), 0);
    chk("t6_done",    32'(done), 0);
    tick();
    chk("t6_abort_clr", 32'(aborted), 0);
    chk("t6_nodone",    32'(done), 0);

    // Reset in the middle of a run
    go(S00, 16'h0000, 5'd8, 1'b1, S11);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_state", 32'(state), 0);
    chk("r_steps", 32'(steps), 0);
    chk("r_busy",  32'(busy), 0);
    chk("r_x",     32'(x_out), 0);
    chk("r_hit",   32'(hit), 0);
    tick();
    chk("r_done", 32'(done), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
